// File: rtl/ppg_pkg.sv
// rtl/ppg_pkg.sv - shared sizes, entry layout and FSM encoding for the pulse-pattern sequencer
package ppg_pkg;

  localparam int DEPTH   = 16;
  localparam int DURW    = 12;
  localparam int REPW    = 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTW    = DURW + 1;

  // Entry layout: level bit on top, hold duration below it.
  localparam int LVL_BIT = DURW;
  localparam int DUR_MSB = DURW - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Index of the entry that follows cur, wrapping to 0 after the last one.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] cur, input logic [AW-1:0] last);
    return (cur == last) ? '0 : cur + AW'(1);
  endfunction

endpackage

// File: rtl/ppg_seq_channel_if.sv
// rtl/ppg_seq_channel_if.sv - configuration, control and output bundle of one sequencer channel
interface ppg_seq_channel_if;
  import ppg_pkg::*;

  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [ENTW-1:0] cfg_wdata;
  logic [AW-1:0]   cfg_len;
  logic [REPW-1:0] cfg_rep;
  logic            idle_lvl;
  logic            start;
  logic            abort;
  logic            cki;
  logic            busy;
  logic            done;
  logic [AW-1:0]   cur_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_rep, idle_lvl, start, abort,
    input  cki, busy, done, cur_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_rep, idle_lvl, start, abort,
    output cki, busy, done, cur_idx
  );

endinterface

// File: rtl/ppg_pattern_ram.sv
// rtl/ppg_pattern_ram.sv - pattern storage, synchronous write and asynchronous read, no reset
module ppg_pattern_ram
  import ppg_pkg::*;
(
  input  logic            clk_fast,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [ENTW-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [ENTW-1:0] rdata
);

  logic [ENTW-1:0] mem [DEPTH];

  // Store one (level, duration) entry per write strobe.
  always_ff @(posedge clk_fast) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ppg_seq_channel.sv
// rtl/ppg_seq_channel.sv - single-channel pulse-pattern sequencer driving cki level changes
module ppg_seq_channel
  import ppg_pkg::*;
(
  input  logic               clk_fast,
  input  logic               rstn,
  ppg_seq_channel_if.slave   bus
);

  logic [0:0]      state;
  logic [DURW-1:0] hold;
  logic [REPW-1:0] pass_left;
  logic [AW-1:0]   len_q;
  logic [AW-1:0]   idx;
  logic            cki_q;
  logic            busy_q;
  logic            done_q;

  logic [AW-1:0]   rd_addr;
  logic [ENTW-1:0] rd_data;
  logic            ram_we;

  // While idle the read port presents entry 0 for the start load; while running it
  // presents the entry that follows the current one so the next load has no gap.
  assign rd_addr = (state == ST_RUN) ? next_idx(idx, len_q) : '0;
  assign ram_we  = bus.cfg_we && (state == ST_IDLE);

  ppg_pattern_ram u_ram (
    .clk_fast (clk_fast),
    .we       (ram_we),
    .waddr    (bus.cfg_addr),
    .wdata    (bus.cfg_wdata),
    .raddr    (rd_addr),
    .rdata    (rd_data)
  );

  // Sequencer FSM: hold counter, entry index, pass counter and registered outputs.
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hold      <= '0;
      pass_left <= '0;
      len_q     <= '0;
      idx       <= '0;
      cki_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        idx    <= '0;
        cki_q  <= bus.idle_lvl;
      end else if (state == ST_IDLE) begin
        cki_q <= bus.idle_lvl;
        if (bus.start) begin
          state     <= ST_RUN;
          busy_q    <= 1'b1;
          idx       <= '0;
          len_q     <= bus.cfg_len;
          pass_left <= bus.cfg_rep;
          cki_q     <= rd_data[LVL_BIT];
          hold      <= rd_data[DUR_MSB:0];
        end
      end else if (hold != '0) begin
        hold <= hold - DURW'(1);
      end else if ((idx != len_q) || (pass_left != '0)) begin
        // Advance to the next entry, or wrap to entry 0 when another pass remains.
        if (idx == len_q) pass_left <= pass_left - REPW'(1);
        idx   <= rd_addr;
        cki_q <= rd_data[LVL_BIT];
        hold  <= rd_data[DUR_MSB:0];
      end else begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        idx    <= '0;
        cki_q  <= bus.idle_lvl;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.cki     = cki_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cur_idx = idx;

endmodule
